// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-source round-robin mux arbiter with registered output stream
// Each grant is bounded to MAX_BURST beats and is followed by one no-accept transition cycle.
module mux_rr_arbiter #(
   parameter int WIDTH     = 2,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);
   localparam int            CW        = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
   logic             r_sel;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   logic             w_free;
   logic             w_own_req;
   logic             w_oth_req;
   logic             w_burst_done;
   logic             w_accept;
   logic             w_enter;
   logic             w_enter_id;
   logic [WIDTH-1:0] w_mux;

   assign w_free       = !r_out_valid || out_ready;
   assign w_own_req    = (r_state == GRANT1) ? req1 : req0;
   assign w_oth_req    = (r_state == GRANT1) ? req0 : req1;
   // cnt reaches MAX_BURST after the last beat; that cycle accepts nothing and hands over
   assign w_burst_done = (r_cnt == BURST_END);
   assign w_accept     = (r_state != IDLE) && w_own_req && w_free && !w_burst_done;
   assign w_mux        = r_sel ? d1 : d0;
   assign w_enter_id   = (w_state_nxt == GRANT1);

   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_enter = 1'b1;
               if (req0 && req1)
                  w_state_nxt = r_last ? GRANT0 : GRANT1;
               else
                  w_state_nxt = req0 ? GRANT0 : GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            if (!w_own_req || w_burst_done) begin
               if (w_oth_req) begin
                  w_enter     = 1'b1;
                  w_state_nxt = (r_state == GRANT0) ? GRANT1 : GRANT0;
               end else if (w_own_req) begin
                  w_enter = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_sel       <= 1'b0;
         r_last      <= 1'b1;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt0  <= (w_state_nxt == GRANT0);
         r_gnt1  <= (w_state_nxt == GRANT1);
         if (w_enter) begin
            r_cnt  <= '0;
            r_sel  <= w_enter_id;
            r_last <= w_enter_id;
         end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_accept) begin
            r_out_data  <= w_mux;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign sel       = r_sel;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
// Directed vector table, async-reset sequence, then random traffic against a transaction model.
module tb_mux_rr_arbiter;
   localparam int W  = 2;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1, out_ready;
   logic [W-1:0] d0, d1;
   logic         gnt0, gnt1, sel, out_valid;
   logic [W-1:0] out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
   );

   typedef struct packed {
      logic         rst;
      logic         r0;
      logic         r1;
      logic [W-1:0] a0;
      logic [W-1:0] a1;
      logic         rdy;
      logic         g0;
      logic         g1;
      logic         s;
      logic         ov;
      logic [W-1:0] od;
   } vec_t;

   vec_t tbl[$];

   // transaction model: owner -1 means nobody holds the mux
   int           m_owner;
   int           m_beats;
   int           m_last;
   logic         m_sel;
   logic         m_ov;
   logic [W-1:0] m_od;

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_last = 1; m_sel = 1'b0; m_ov = 1'b0; m_od = '0;
   endtask

   task automatic model_enter(input int who);
      m_owner = who; m_beats = 0; m_last = who; m_sel = (who == 1);
   endtask

   task automatic model_step(input logic r0, input logic r1, input logic [W-1:0] a0,
                             input logic [W-1:0] a1, input logic rdy);
      logic         rq[2];
      logic [W-1:0] dat[2];
      logic         free;
      int           o;
      rq[0] = r0; rq[1] = r1; dat[0] = a0; dat[1] = a1;
      free = !m_ov || rdy;
      if (m_owner < 0) begin
         if (m_ov && rdy) m_ov = 1'b0;
         if (rq[0] && rq[1]) model_enter(1 - m_last);
         else if (rq[0])     model_enter(0);
         else if (rq[1])     model_enter(1);
      end else begin
         o = m_owner;
         if (rq[o] && m_beats < MB && free) begin
            m_od = dat[o]; m_ov = 1'b1; m_beats++;
         end else begin
            if (m_ov && rdy) m_ov = 1'b0;
            if (!rq[o] || m_beats == MB) begin
               if (rq[1-o])    model_enter(1 - o);
               else if (rq[o]) model_enter(o);
               else            m_owner = -1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic g0, input logic g1, input logic s,
                             input logic ov, input logic [W-1:0] od);
      chk({tag, ".gnt0"}, gnt0, g0);
      chk({tag, ".gnt1"}, gnt1, g1);
      chk({tag, ".sel"}, sel, s);
      chk({tag, ".out_valid"}, out_valid, ov);
      chk({tag, ".out_data"}, out_data, od);
   endtask

   task automatic drive(input logic r0, input logic r1, input logic [W-1:0] a0,
                        input logic [W-1:0] a1, input logic rdy);
      req0 = r0; req1 = r1; d0 = a0; d1 = a1; out_ready = rdy;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      drive(0, 0, '0, '0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, '0, '0, 0);
      model_reset();

      // single source: 4 beats, re-entry gap, 4 beats
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      // contention: 4x01, gap, 4x10, gap, 01...
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01});
      for (int i = 0; i < 4; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      // backpressure for 3 cycles with new d0 waiting, then the 3 remaining beats
      for (int i = 0; i < 3; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      for (int i = 0; i < 3; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11});
      // early release of source 1 after 2 beats
      for (int i = 0; i < 2; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01});
      // idle return with the last beat held until out_ready
      for (int i = 0; i < 2; i++)
         tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01});

      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);

      foreach (tbl[i]) begin
         if (tbl[i].rst) apply_reset();
         drive(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].rdy);
         cycle();
         check_outs($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].s, tbl[i].ov, tbl[i].od);
      end

      // asynchronous reset mid-burst, observed before any clock edge
      apply_reset();
      drive(1, 0, 2'b01, 2'b00, 1);
      repeat (3) cycle();
      chk("pre_rst.gnt0", gnt0, 1'b1);
      chk("pre_rst.out_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      drive(1, 1, 2'b01, 2'b10, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("post_rst.gnt0", gnt0, 1'b1);
      chk("post_rst.gnt1", gnt1, 1'b0);

      apply_reset();
      for (int n = 0; n < 3000; n++) begin
         logic         r0, r1, rdy;
         logic [W-1:0] a0, a1;
         r0  = ($urandom_range(0, 3) != 0);
         r1  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 9) < 7);
         a0  = W'($urandom);
         a1  = W'($urandom);
         drive(r0, r1, a0, a1, rdy);
         model_step(r0, r1, a0, a1, rdy);
         cycle();
         check_outs($sformatf("rnd%0d", n), (m_owner == 0), (m_owner == 1), m_sel, m_ov,
                    m_ov ? m_od : out_data);
         chk($sformatf("rnd%0d.onehot", n), gnt0 & gnt1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
